md5_iterative_core: RTL and testbench
=====================================

// Module: md5_iterative_core
// PURPOSE
//  Parametrised successor to the fully unrolled single-cycle MD5 engine. Computes the MD5 digest of one
//  variable-length message (0..MSG_WIDTH/8 bytes, always a single 512-bit block) with standard MD5 padding.
//  The 64 MD5 steps run on STEPS_PER_CYCLE chained md5_operation instances per clock.
//  Sits behind the candidate generator in the cracker. Uses a ready/new_message handshake and a held valid.
// PARAMETERS
//  MSG_WIDTH        128  max message bits; multiple of 8, 8..440 (single-block limit)
//  STEPS_PER_CYCLE  4    MD5 steps per clock; one of 1,2,4,8,16,32,64
//  LEN_W            6    width of msg_len; must satisfy 2**LEN_W > MSG_WIDTH/8
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          synchronous, active-high reset
//  message      in   MSG_WIDTH  message bytes; byte 0 = message[MSG_WIDTH-1 -: 8]
//  msg_len      in   LEN_W      message length in bytes
//  new_message  in   1          start request; accepted only when ready=1
//  ready        out  1          core can accept a message (IDLE or DONE)
//  valid        out  1          digest/value hold a completed result
//  digest       out  128        MD5 digest, canonical byte order (byte 0 in [127:120])
//  value        out  MSG_WIDTH  message that produced digest
//  match        out  1          only with MD5_TARGET_COMPARE_EN (see CONFIGURATION)
//  target       in   128        only with MD5_TARGET_COMPARE_EN; same byte order as digest
// BEHAVIOUR
//  - Reset (synchronous, active-high): state=IDLE; ready=1; valid=0; digest=0; value=0; match=0. Reset
//    applied mid-RUN aborts the computation. No partial result is output.
//  - FSM:
//    IDLE --(new_message)--> RUN
//    RUN --(step counter reaches 64)--> DONE
//    DONE --(new_message)--> RUN
//  - Capture: on acceptance, latch message and L = min(msg_len, MSG_WIDTH/8). Load A..D = 67452301,
//    efcdab89, 98badcfe, 10325476 and set step counter = 0.
//  - Padding: block byte i = message byte i for i<L; byte L = 0x80; other bytes = 0. Bytes 56..63 =
//    64-bit little-endian L*8. MD5 word Mj = bytes 4j..4j+3, little-endian.
//  - RUN: each clock applies steps k..k+STEPS_PER_CYCLE-1 combinationally, then k += STEPS_PER_CYCLE.
//    Round = k[5:4], phase = k[3:0].
//  - Latency: accept at edge N; valid=1 and results stable after edge N+64/STEPS_PER_CYCLE.
//  - Final: digest words = (A+67452301, B+efcdab89, C+98badcfe, D+10325476) mod 2^32. Each word is
//    byte-swapped into canonical order.
//  - valid stays high in DONE until the next accepted message. valid drops the cycle after acceptance.
//    digest, value and match are held while valid=1.
//  - ready=0 throughout RUN. new_message during RUN, including the final RUN cycle, is ignored and not
//    queued.
//  - new_message held high in DONE starts back-to-back jobs, giving a 1-cycle valid pulse per job.
//  - msg_len > MSG_WIDTH/8 is clamped to MSG_WIDTH/8. msg_len = 0 hashes the empty message.
//  - All adds are 32-bit wrap-around. Rotations use the standard MD5 per-step shift table.
// CONFIGURATION
//  MD5_TARGET_COMPARE_EN defined: adds target input and match output. target is latched at acceptance.
//    match = (digest == latched target), registered with valid. match is 0 whenever valid=0.
//  MD5_TARGET_COMPARE_EN undefined: no target/match ports; no comparator logic.
// TESTING
//  1. Empty message: msg_len=0, pulse new_message -> after 64/STEPS_PER_CYCLE cycles valid=1,
//     digest=d41d8cd98f00b204e9800998ecf8427e.
//  2. "abc", msg_len=3 -> digest=900150983cd24fb0d6963f7d28e17f72, value echoes message.
//     Repeat with STEPS_PER_CYCLE=1,4,64: latency 64, 16, 1 cycles.
//  3. Busy and overflow: pulse new_message mid-RUN with other data -> ignored; "abc" result unchanged.
//     msg_len=63, MSG_WIDTH=128 -> clamped to 16 bytes; equals hash of the 16-byte message.
//  4. Reset mid-RUN at step 32 -> next cycle valid=0, ready=1, digest=0. A fresh "a" job ->
//     0cc175b9c0f1b6a831c399e269772661.
//  5. new_message held high in DONE over 3 distinct messages -> 3 consecutive correct digests, each
//     valid for 1 cycle, with no lost or repeated job.
//  6. MD5_TARGET_COMPARE_EN defined: target=900150983cd24fb0d6963f7d28e17f72, hash "abc" -> match=1.
//     Hash "abd" -> match=0.

Source files
------------

// File: rtl/md5_iterative_core.sv
// Iterative single-block MD5 core: STEPS_PER_CYCLE chained MD5 steps per clock, held result.
// Optional feature macro MD5_TARGET_COMPARE_EN adds a latched target and a registered match flag.
module md5_iterative_core #(
    parameter int MSG_WIDTH       = 128,
    parameter int STEPS_PER_CYCLE = 4,
    parameter int LEN_W           = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MSG_WIDTH-1:0] message,
    input  logic [LEN_W-1:0]     msg_len,
    input  logic                 new_message,
    output logic                 ready,
    output logic                 valid,
    output logic [127:0]         digest,
    output logic [MSG_WIDTH-1:0] value
`ifdef MD5_TARGET_COMPARE_EN
    ,
    output logic                 match,
    input  logic [127:0]         target
`endif
);

    localparam int NB = MSG_WIDTH / 8;
    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [6:0]             step_q;
    logic [127:0]           abcd_q, abcd_n;
    logic [15:0][31:0]      m_q;
    logic [MSG_WIDTH-1:0]   msg_q;
    logic [LEN_W-1:0]       len_c;
    logic [8:0]             pad_pos;
    logic [511:0]           blk;
    logic [127:0]           final_digest;
    logic                   accept, last;
`ifdef MD5_TARGET_COMPARE_EN
    logic [127:0]           target_q;
`endif

    function automatic logic [31:0] md5_k(input logic [5:0] i);
        case (i)
            6'd0:  return 32'hd76aa478; 6'd1:  return 32'he8c7b756; 6'd2:  return 32'h242070db; 6'd3:  return 32'hc1bdceee;
            6'd4:  return 32'hf57c0faf; 6'd5:  return 32'h4787c62a; 6'd6:  return 32'ha8304613; 6'd7:  return 32'hfd469501;
            6'd8:  return 32'h698098d8; 6'd9:  return 32'h8b44f7af; 6'd10: return 32'hffff5bb1; 6'd11: return 32'h895cd7be;
            6'd12: return 32'h6b901122; 6'd13: return 32'hfd987193; 6'd14: return 32'ha679438e; 6'd15: return 32'h49b40821;
            6'd16: return 32'hf61e2562; 6'd17: return 32'hc040b340; 6'd18: return 32'h265e5a51; 6'd19: return 32'he9b6c7aa;
            6'd20: return 32'hd62f105d; 6'd21: return 32'h02441453; 6'd22: return 32'hd8a1e681; 6'd23: return 32'he7d3fbc8;
            6'd24: return 32'h21e1cde6; 6'd25: return 32'hc33707d6; 6'd26: return 32'hf4d50d87; 6'd27: return 32'h455a14ed;
            6'd28: return 32'ha9e3e905; 6'd29: return 32'hfcefa3f8; 6'd30: return 32'h676f02d9; 6'd31: return 32'h8d2a4c8a;
            6'd32: return 32'hfffa3942; 6'd33: return 32'h8771f681; 6'd34: return 32'h6d9d6122; 6'd35: return 32'hfde5380c;
            6'd36: return 32'ha4beea44; 6'd37: return 32'h4bdecfa9; 6'd38: return 32'hf6bb4b60; 6'd39: return 32'hbebfbc70;
            6'd40: return 32'h289b7ec6; 6'd41: return 32'heaa127fa; 6'd42: return 32'hd4ef3085; 6'd43: return 32'h04881d05;
            6'd44: return 32'hd9d4d039; 6'd45: return 32'he6db99e5; 6'd46: return 32'h1fa27cf8; 6'd47: return 32'hc4ac5665;
            6'd48: return 32'hf4292244; 6'd49: return 32'h432aff97; 6'd50: return 32'hab9423a7; 6'd51: return 32'hfc93a039;
            6'd52: return 32'h655b59c3; 6'd53: return 32'h8f0ccc92; 6'd54: return 32'hffeff47d; 6'd55: return 32'h85845dd1;
            6'd56: return 32'h6fa87e4f; 6'd57: return 32'hfe2ce6e0; 6'd58: return 32'ha3014314; 6'd59: return 32'h4e0811a1;
            6'd60: return 32'hf7537e82; 6'd61: return 32'hbd3af235; 6'd62: return 32'h2ad7d2bb; default: return 32'heb86d391;
        endcase
    endfunction

    function automatic logic [4:0] md5_s(input logic [5:0] i);
        case ({i[5:4], i[1:0]})
            4'h0: return 5'd7;  4'h1: return 5'd12; 4'h2: return 5'd17; 4'h3: return 5'd22;
            4'h4: return 5'd5;  4'h5: return 5'd9;  4'h6: return 5'd14; 4'h7: return 5'd20;
            4'h8: return 5'd4;  4'h9: return 5'd11; 4'ha: return 5'd16; 4'hb: return 5'd23;
            4'hc: return 5'd6;  4'hd: return 5'd10; 4'he: return 5'd15; default: return 5'd21;
        endcase
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // One MD5 step on {A,B,C,D}; message word index derives from round and phase.
    function automatic logic [127:0] md5_step(input logic [127:0] abcd, input logic [5:0] idx,
                                              input logic [15:0][31:0] m);
        logic [31:0] a, b, c, d, f, t, rot;
        logic [3:0]  p, g;
        logic [4:0]  s;
        {a, b, c, d} = abcd;
        p = idx[3:0];
        case (idx[5:4])
            2'd0:    begin f = (b & c) | (~b & d); g = p;                 end
            2'd1:    begin f = (d & b) | (~d & c); g = p * 4'd5 + 4'd1;   end
            2'd2:    begin f = b ^ c ^ d;          g = p * 4'd3 + 4'd5;   end
            default: begin f = c ^ (b | ~d);       g = p * 4'd7;          end
        endcase
        s   = md5_s(idx);
        t   = a + f + md5_k(idx) + m[g];
        rot = (t << s) | (t >> (6'd32 - {1'b0, s}));
        return {d, b + rot, b, c};
    endfunction

    assign ready  = (state_q != RUN);
    assign valid  = (state_q == DONE);
    assign accept = ready && new_message;
    assign last   = (step_q == 7'(64 - STEPS_PER_CYCLE));

    // Padded block as a flat vector: byte i sits at bits [8i+7:8i], so word j is blk[32j+:32].
    always_comb begin
        len_c   = (msg_len > LEN_W'(NB)) ? LEN_W'(NB) : msg_len;
        pad_pos = 9'({len_c, 3'b000});
        blk     = '0;
        for (int i = 0; i < NB; i++) begin
            if (LEN_W'(i) < len_c)
                blk[8*i +: 8] = message[MSG_WIDTH-1-8*i -: 8];
        end
        blk[pad_pos +: 8] = 8'h80;
        blk[511:448]      = 64'(len_c) << 3;
    end

    always_comb begin
        abcd_n = abcd_q;
        for (int j = 0; j < STEPS_PER_CYCLE; j++)
            abcd_n = md5_step(abcd_n, step_q[5:0] + 6'(j), m_q);
        final_digest = {bswap32(abcd_n[127:96] + IV[127:96]), bswap32(abcd_n[95:64] + IV[95:64]),
                        bswap32(abcd_n[63:32]  + IV[63:32]),  bswap32(abcd_n[31:0]  + IV[31:0])};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_message) state_d = RUN;
            RUN:     if (last)        state_d = DONE;
            DONE:    if (new_message) state_d = RUN;
            default:                  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            digest  <= '0;
            value   <= '0;
`ifdef MD5_TARGET_COMPARE_EN
            match   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                msg_q  <= message;
                m_q    <= blk;
                abcd_q <= IV;
                step_q <= '0;
`ifdef MD5_TARGET_COMPARE_EN
                target_q <= target;
                match    <= 1'b0;
`endif
            end else if (state_q == RUN) begin
                abcd_q <= abcd_n;
                step_q <= step_q + 7'(STEPS_PER_CYCLE);
                if (last) begin
                    digest <= final_digest;
                    value  <= msg_q;
`ifdef MD5_TARGET_COMPARE_EN
                    match  <= (final_digest == target_q);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_md5_iterative_core.sv
// Scoreboard bench for md5_iterative_core: known-answer digests plus a reference MD5 model.
module tb_md5_iterative_core;

    localparam int MW = 128;
    localparam int S  = 4;
    localparam int LW = 6;

    localparam logic [127:0] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] D_A     = 128'h0cc175b9c0f1b6a831c399e269772661;
    localparam logic [127:0] D_MD    = 128'hf96b697d7cb7938d525a2f31aaf161d0;
    localparam logic [127:0] M_ABC   = {8'h61, 8'h62, 8'h63, 104'h0};
    localparam logic [127:0] M_ABD   = {8'h61, 8'h62, 8'h64, 104'h0};
    localparam logic [127:0] M_A     = {8'h61, 120'h0};
    localparam logic [127:0] M_XYZ   = {8'h78, 8'h79, 8'h7a, 104'h0};
    localparam logic [127:0] M_MD    = {112'h6d65737361676520646967657374, 16'h0};
    localparam logic [127:0] M_16    = 128'h30313233343536373839616263646566;

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    localparam int SHR [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [MW-1:0]   message = '0;
    logic [LW-1:0]   msg_len = '0;
    logic            new_message = 1'b0;
    logic            ready, valid;
    logic [127:0]    digest;
    logic [MW-1:0]   value;
`ifdef MD5_TARGET_COMPARE_EN
    logic            match;
    logic [127:0]    target = '0;
`endif

    typedef struct packed {
        logic [127:0] d;
        logic [127:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    md5_iterative_core #(.MSG_WIDTH(MW), .STEPS_PER_CYCLE(S), .LEN_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .message     (message),
        .msg_len     (msg_len),
        .new_message (new_message),
        .ready       (ready),
        .valid       (valid),
        .digest      (digest),
        .value       (value)
`ifdef MD5_TARGET_COMPARE_EN
        ,
        .match       (match),
        .target      (target)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Textbook MD5 over one padded block of a message up to 16 bytes.
    function automatic logic [127:0] md5_ref(input logic [127:0] msg, input int len);
        logic [7:0]  blk [64];
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, tmp;
        int          g, sh;
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < len; i++) blk[i] = msg[127-8*i -: 8];
        blk[len] = 8'h80;
        blk[56]  = 8'(len * 8);
        blk[57]  = 8'((len * 8) >> 8);
        for (int j = 0; j < 16; j++) w[j] = {blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7*i) % 16;     end
            sh  = SHR[i/16][i%4];
            f   = f + a + K_TAB[i] + w[g];
            tmp = d; d = c; c = b;
            b   = b + ((f << sh) | (f >> (32 - sh)));
            a   = tmp;
        end
        return {bswap(a + 32'h67452301), bswap(b + 32'hefcdab89),
                bswap(c + 32'h98badcfe), bswap(d + 32'h10325476)};
    endfunction

    task automatic send(input logic [127:0] m, input logic [LW-1:0] l, input logic [127:0] d);
        @(negedge clk);
        message     = m;
        msg_len     = l;
        new_message = 1'b1;
        sb.push_back('{d: d, v: m});
        @(posedge clk);
        #1 new_message = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!valid && cyc < 200);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (digest !== 128'h0) $display("FAIL reset_digest: got %h want 0", digest); else n_pass++;
        n_checks++; if (value !== '0) $display("FAIL reset_value: got %h want 0", value); else n_pass++;
`ifdef MD5_TARGET_COMPARE_EN
        n_checks++; if (match !== 1'b0) $display("FAIL reset_match: got %b want 0", match); else n_pass++;
`endif
    endtask

    task automatic test_empty();
        exp_t e;
        int   cyc;
        send(128'h0, '0, D_EMPTY);
        n_checks++; if (ready !== 1'b0) $display("FAIL empty_ready_run: got %b want 0", ready); else n_pass++;
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== 64/S) $display("FAIL empty_latency: got %0d want %0d", cyc, 64/S); else n_pass++;
        n_checks++; if (digest !== e.d) $display("FAIL empty_digest: got %h want %h", digest, e.d); else n_pass++;
        n_checks++; if (value !== e.v) $display("FAIL empty_value: got %h want %h", value, e.v); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (valid !== 1'b1 || digest !== e.d)
            $display("FAIL empty_hold: got valid=%b digest=%h want valid=1 digest=%h", valid, digest, e.d);
        else n_pass++;
    endtask

    task automatic test_abc();
        exp_t e;
        int   cyc;
        send(M_ABC, 6'd3, D_ABC);
        n_checks++; if (valid !== 1'b0) $display("FAIL abc_valid_drop: got %b want 0", valid); else n_pass++;
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== 64/S) $display("FAIL abc_latency: got %0d want %0d", cyc, 64/S); else n_pass++;
        n_checks++; if (digest !== e.d) $display("FAIL abc_digest: got %h want %h", digest, e.d); else n_pass++;
        n_checks++; if (value !== e.v) $display("FAIL abc_value: got %h want %h", value, e.v); else n_pass++;
    endtask

    task automatic test_busy();
        exp_t e;
        int   cyc;
        send(M_ABC, 6'd3, D_ABC);
        repeat (4) @(posedge clk);
        #1;
        message     = M_XYZ;
        msg_len     = 6'd3;
        new_message = 1'b1;
        wait_valid(cyc);
        new_message = 1'b0;
        e = sb.pop_front();
        n_checks++; if (cyc !== 64/S - 4) $display("FAIL busy_latency: got %0d want %0d", cyc, 64/S - 4); else n_pass++;
        n_checks++; if (digest !== e.d) $display("FAIL busy_digest: got %h want %h", digest, e.d); else n_pass++;
        n_checks++; if (value !== e.v) $display("FAIL busy_value: got %h want %h", value, e.v); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (valid !== 1'b1 || ready !== 1'b1)
            $display("FAIL busy_not_queued: got valid=%b ready=%b want 1 1", valid, ready);
        else n_pass++;
    endtask

    task automatic test_overflow();
        exp_t e;
        int   cyc;
        send(M_16, 6'd63, md5_ref(M_16, 16));
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (digest !== e.d) $display("FAIL clamp_digest: got %h want %h", digest, e.d); else n_pass++;
        n_checks++; if (value !== e.v) $display("FAIL clamp_value: got %h want %h", value, e.v); else n_pass++;
        send(M_16, 6'd15, md5_ref(M_16, 15));
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (digest !== e.d) $display("FAIL len15_digest: got %h want %h", digest, e.d); else n_pass++;
    endtask

    task automatic test_random();
        exp_t         e;
        int           cyc, len;
        logic [127:0] m;
        for (int k = 0; k < 4; k++) begin
            len = $urandom_range(0, 16);
            m   = {$urandom, $urandom, $urandom, $urandom};
            send(m, 6'(len), md5_ref(m, len));
            wait_valid(cyc);
            e = sb.pop_front();
            n_checks++; if (digest !== e.d || value !== e.v)
                $display("FAIL random_%0d (len %0d): got %h/%h want %h/%h", k, len, digest, value, e.d, e.v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   cyc;
        send(M_ABC, 6'd3, D_ABC);
        repeat (32/S) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        n_checks++; if (valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", ready); else n_pass++;
        n_checks++; if (digest !== 128'h0) $display("FAIL abort_digest: got %h want 0", digest); else n_pass++;
        send(M_A, 6'd1, D_A);
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (cyc !== 64/S) $display("FAIL fresh_latency: got %0d want %0d", cyc, 64/S); else n_pass++;
        n_checks++; if (digest !== e.d) $display("FAIL fresh_digest: got %h want %h", digest, e.d); else n_pass++;
        n_checks++; if (value !== e.v) $display("FAIL fresh_value: got %h want %h", value, e.v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0]  msgs [3] = '{M_A, M_MD, M_ABC};
        logic [LW-1:0] lens [3] = '{6'd1, 6'd14, 6'd3};
        logic [127:0]  exps [3] = '{D_A, D_MD, D_ABC};
        fork
            begin
                int cnt;
                for (int k = 0; k < 3; k++) begin
                    message     = msgs[k];
                    msg_len     = lens[k];
                    new_message = 1'b1;
                    sb.push_back('{d: exps[k], v: msgs[k]});
                    cnt = 0;
                    while (!ready && cnt < 200) begin
                        @(posedge clk);
                        #1 cnt++;
                    end
                    @(posedge clk);
                    #1;
                end
                new_message = 1'b0;
            end
            begin
                exp_t e;
                int   cyc;
                for (int k = 0; k < 3; k++) begin
                    wait_valid(cyc);
                    n_checks++; if (!valid || sb.size() == 0) $display("FAIL b2b_timeout_%0d: got valid=%b want 1", k, valid);
                    else n_pass++;
                    if (sb.size() != 0) e = sb.pop_front();
                    n_checks++; if (digest !== e.d) $display("FAIL b2b_digest_%0d: got %h want %h", k, digest, e.d); else n_pass++;
                    n_checks++; if (value !== e.v) $display("FAIL b2b_value_%0d: got %h want %h", k, value, e.v); else n_pass++;
                    @(posedge clk);
                    #1;
                    n_checks++; if (valid !== (k == 2))
                        $display("FAIL b2b_pulse_%0d: got valid=%b want %b", k, valid, (k == 2));
                    else n_pass++;
                end
            end
        join
    endtask

`ifdef MD5_TARGET_COMPARE_EN
    task automatic test_target();
        exp_t e;
        int   cyc;
        target = D_ABC;
        send(M_ABC, 6'd3, D_ABC);
        n_checks++; if (match !== 1'b0) $display("FAIL match_run: got %b want 0", match); else n_pass++;
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (match !== 1'b1) $display("FAIL match_abc: got %b want 1", match); else n_pass++;
        n_checks++; if (digest !== e.d) $display("FAIL match_abc_digest: got %h want %h", digest, e.d); else n_pass++;
        send(M_ABD, 6'd3, md5_ref(M_ABD, 3));
        wait_valid(cyc);
        e = sb.pop_front();
        n_checks++; if (match !== 1'b0) $display("FAIL match_abd: got %b want 0", match); else n_pass++;
        n_checks++; if (digest !== e.d) $display("FAIL match_abd_digest: got %h want %h", digest, e.d); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_busy();
        test_overflow();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MD5_TARGET_COMPARE_EN
        test_target();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
